ram_bus_arbiter: RTL



---
 rtl/ram_bus_arbiter.sv | 101 ++++++++++
 1 files changed

// File: rtl/ram_bus_arbiter.sv
// ram_bus_arbiter: round-robin IF/LS arbiter that serialises 1/2/4-byte transfers onto a byte-wide RAM port
module ram_bus_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [1:0]        ls_size,
  input  logic              ls_signed,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_done,
  output logic [31:0]       ls_rdata,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr
);
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
  state_t state, state_n;
  logic [2:0] cnt, n, off;
  logic [ADDR_W-1:0] base;
  logic [1:0] size;
  logic [31:0] wdata, buf_q, buf_n, ext;
  logic own_if, sgn, last_if, if_done_q, ls_done_q;
  logic if_ok, ls_ok, grant, pick_if, last_rd, last_wr;
  assign if_ok = if_req && !if_done_q && !flush;
  assign ls_ok = ls_req && !ls_done_q;
  assign grant = if_ok || ls_ok;
  assign pick_if = if_ok && (!ls_ok || !last_if);
  assign last_rd = cnt == n;
  assign last_wr = cnt == n - 3'd1;
  assign off = state == READ && last_rd ? n - 3'd1 : cnt;
  assign ram_a = state == IDLE ? '0 : base + ADDR_W'(off);
  assign ram_wr = rdy && state == WRITE;
  assign ram_dout = state == WRITE ? wdata[{cnt[1:0], 3'b000} +: 8] : 8'd0;
  assign if_done = if_done_q && rdy;
  assign ls_done = ls_done_q && rdy;
  assign ext = size == 2'd0 ? {{24{sgn & buf_n[7]}}, buf_n[7:0]} :
               size == 2'd1 ? {{16{sgn & buf_n[15]}}, buf_n[15:0]} : buf_n;
  always_comb begin
    buf_n = buf_q;
    if (cnt != 3'd0) buf_n[{cnt[1:0] - 2'd1, 3'b000} +: 8] = ram_din;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = grant ? (!pick_if && ls_we ? WRITE : READ) : IDLE;
      READ:    state_n = (own_if && flush) || last_rd ? IDLE : READ;
      WRITE:   state_n = last_wr ? IDLE : WRITE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else if (rdy) state <= state_n;
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= 3'd0;
      n <= 3'd0;
      base <= '0;
      size <= 2'd0;
      wdata <= 32'd0;
      buf_q <= 32'd0;
      own_if <= 1'b0;
      sgn <= 1'b0;
      last_if <= 1'b1;
      if_done_q <= 1'b0;
      ls_done_q <= 1'b0;
      if_data <= 32'd0;
      ls_rdata <= 32'd0;
    end else if (rdy) begin
      if_done_q <= 1'b0;
      ls_done_q <= 1'b0;
      cnt <= state == IDLE ? 3'd0 : cnt + 3'd1;
      if (state == IDLE && grant) begin
        own_if <= pick_if;
        last_if <= pick_if;
        base <= pick_if ? if_addr : ls_addr;
        size <= pick_if ? 2'd2 : ls_size;
        n <= pick_if || ls_size[1] ? 3'd4 : ls_size[0] ? 3'd2 : 3'd1;
        sgn <= ls_signed;
        wdata <= ls_wdata;
      end
      if (state == READ) buf_q <= buf_n;
      if (state == READ && last_rd && !(own_if && flush)) begin
        if_done_q <= own_if;
        ls_done_q <= !own_if;
        if (own_if) if_data <= buf_n;
        else ls_rdata <= ext;
      end
      if (state == WRITE && last_wr) ls_done_q <= 1'b1;
    end
endmodule
